// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: WS2812-class frame serializer with valid/ready pixel input and a trailing latch interval.
// Optional build macro LED_REPEAT_ON_UNDERRUN_EN: repeat the last pixel on underrun instead of aborting to latch.
module led_frame_sequencer #(
    parameter int NUM_LEDS  = 8,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int TBIT_CYC  = 63,
    parameter int LATCH_CYC = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        px_valid,
    input  logic [23:0] px_data,
    output logic        px_ready,
    output logic        led_out,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam int MAXC = (LATCH_CYC > TBIT_CYC) ? LATCH_CYC : TBIT_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam int PW   = $clog2(NUM_LEDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] px_cnt;
    logic [4:0]    bit_idx;
    logic [23:0]   px_word;
    logic          cur_bit;
    logic [CW-1:0] hi_last;
    logic [CW-1:0] lo_last;

    // Terminal counts of the high and low phases for the bit currently on the wire
    always_comb begin
        cur_bit = px_word[bit_idx];
        hi_last = cur_bit ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
        lo_last = cur_bit ? CW'(TBIT_CYC - T1H_CYC - 1) : CW'(TBIT_CYC - T0H_CYC - 1);
    end

    // Frame FSM; every output is a flop updated together with the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            px_cnt   <= '0;
            bit_idx  <= '0;
            px_word  <= '0;
            px_ready <= 1'b0;
            led_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    px_ready <= 1'b1;
                    busy     <= 1'b1;
                    underrun <= 1'b0;
                    px_cnt   <= '0;
                    px_word  <= '0;
                end
                LOAD: begin
                    px_ready <= 1'b0;
                    cnt      <= '0;
                    bit_idx  <= 5'd23;
                    px_cnt   <= px_cnt + PW'(1);
                    if (px_valid) px_word <= px_data;
                    else underrun <= 1'b1;
`ifdef LED_REPEAT_ON_UNDERRUN_EN
                    state   <= HIGH;
                    led_out <= 1'b1;
`else
                    state   <= px_valid ? HIGH : LATCH;
                    led_out <= px_valid;
`endif
                end
                HIGH: if (cnt == hi_last) begin
                    state   <= LOW;
                    led_out <= 1'b0;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                LOW: if (cnt == lo_last) begin
                    cnt <= '0;
                    if (bit_idx != 5'd0) begin
                        bit_idx <= bit_idx - 5'd1;
                        state   <= HIGH;
                        led_out <= 1'b1;
                    end else if (px_cnt < PW'(NUM_LEDS)) begin
                        state    <= LOAD;
                        px_ready <= 1'b1;
                    end else begin
                        state <= LATCH;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                LATCH: if (cnt == CW'(LATCH_CYC - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: frame-timeline model checked every cycle plus directed frame measurements.
module tb_led_frame_sequencer;
    localparam int N    = 2;
    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int TBIT = 63;
    localparam int LAT  = 2500;
    localparam int PIX  = 1 + 24 * TBIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b1;
    logic        px_valid = 1'b0;
    logic [23:0] px_data = '0;
    logic        px_ready, led_out, busy, done, underrun;
    int          checks = 0;
    int          passes = 0;

    led_frame_sequencer #(.NUM_LEDS(N), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .LATCH_CYC(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .px_valid(px_valid), .px_data(px_data),
        .px_ready(px_ready), .led_out(led_out), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: offset m_o from the first LOAD cycle of a frame; pixels occupy PIX cycles each until m_lat, then LAT latch cycles
    bit          m_act = 1'b0;
    bit          m_done = 1'b0;
    bit          m_under = 1'b0;
    int          m_o = 0;
    int          m_lat = 0;
    logic [23:0] m_word = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act   <= 1'b0;
            m_done  <= 1'b0;
            m_under <= 1'b0;
        end else if (!m_act) begin
            m_done <= 1'b0;
            if (start) begin
                m_act   <= 1'b1;
                m_o     <= 0;
                m_lat   <= N * PIX;
                m_under <= 1'b0;
                m_word  <= '0;
            end
        end else begin
            if (m_o < m_lat && m_o % PIX == 0) begin
                if (px_valid) m_word <= px_data;
                else begin
                    m_under <= 1'b1;
`ifndef LED_REPEAT_ON_UNDERRUN_EN
                    m_lat <= m_o + 1;
`endif
                end
            end
            m_o <= m_o + 1;
            if (m_o + 1 == m_lat + LAT) begin
                m_act  <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic e_led, e_rdy;
        int   r;
        e_led = 1'b0;
        e_rdy = 1'b0;
        if (rst_n && m_act && m_o < m_lat) begin
            r = m_o % PIX;
            if (r == 0) e_rdy = 1'b1;
            else e_led = ((r - 1) % TBIT) < (m_word[23 - (r - 1) / TBIT] ? T1H : T0H);
        end
        chk("led_out", led_out, e_led);
        chk("px_ready", px_ready, e_rdy);
        chk("busy", busy, rst_n && m_act);
        chk("done", done, rst_n && m_done);
        chk("underrun", underrun, rst_n && m_under);
    end

    // Runs one frame; c counts cycles from the first LOAD. Returns at the negedge of the done cycle.
    task automatic frame(input logic [23:0] d0, input logic [23:0] d1, input bit drop, input bit pre,
                         output int blen, output int hi0, output int hi1, output int rgap, output int rcnt);
        int first_r;
        bit got;
        blen = 0; hi0 = 0; hi1 = 0; rgap = 0; rcnt = 0; first_r = -1; got = 1'b0;
        if (!pre) begin
            @(posedge clk); #1;
            start = 1'b1;
        end
        px_valid = 1'b1;
        px_data  = d0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (busy) blen++;
            if (px_ready) begin
                rcnt++;
                if (first_r < 0) first_r = c;
                else rgap = c - first_r;
            end
            if (led_out) begin
                if (c < PIX) hi0++;
                else hi1++;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            px_data  = (c + 1 >= PIX) ? d1 : d0;
            px_valid = !(drop && c + 1 == PIX);
            start    = (c + 1 == 30 || c + 1 == 50 || c + 1 == 3000 || c + 1 == 5000);
        end
        chk("frame_done_seen", got, 1'b1);
    endtask

    initial begin
        int blen, hi0, hi1, rgap, rcnt, w;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_led", led_out, 0);
        chk("rst_ready", px_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        frame(24'hF00000, 24'h0F0F0F, 1'b0, 1'b0, blen, hi0, hi1, rgap, rcnt);
        chk("a_busy_len", blen, 5526);
        chk("a_hi0", hi0, 560);
        chk("a_hi1", hi1, 720);
        chk("a_ready_cnt", rcnt, 2);
        chk("a_ready_gap", rgap, 1513);
        chk("a_underrun", underrun, 0);

        start = 1'b1;
        frame(24'hA5A5A5, 24'h000000, 1'b1, 1'b1, blen, hi0, hi1, rgap, rcnt);
`ifdef LED_REPEAT_ON_UNDERRUN_EN
        chk("b_busy_len", blen, 5526);
        chk("b_hi1", hi1, 720);
`else
        chk("b_busy_len", blen, 4014);
        chk("b_hi1", hi1, 0);
`endif
        chk("b_hi0", hi0, 720);
        chk("b_ready_cnt", rcnt, 2);
        chk("b_underrun", underrun, 1);
        px_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("b_idle_busy", busy, 0);
        chk("b_sticky", underrun, 1);

        start    = 1'b1;
        px_valid = 1'b1;
        px_data  = 24'hFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!led_out && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("r_led_rise", led_out, 1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_led", led_out, 0);
        chk("r_async_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("r_idle_busy", busy, 0);

        frame(24'h123456, 24'hFEDCBA, 1'b0, 1'b0, blen, hi0, hi1, rgap, rcnt);
        chk("c_busy_len", blen, 5526);
        chk("c_hi0", hi0, 660);
        chk("c_hi1", hi1, 820);
        chk("c_ready_gap", rgap, 1513);
        chk("c_underrun", underrun, 0);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Frame controller for a chain of WS2812-class smart LEDs. It pulls 24-bit pixel words from an upstream source through a valid/ready handshake and serializes each word MSB-first onto a single-wire output using cycle-counted high/low pulse widths. Each frame ends with a low latch interval. The block sits between the pixel source (pins or a register bank) and the `led_out` pad inside the tile top level.

## Interface
Parameters:
- `NUM_LEDS`, 8: pixels per frame; legal range ≥1.
- `T0H_CYC`, 20: high time of a 0 bit, in clk cycles (400 ns at 50 MHz).
- `T1H_CYC`, 40: high time of a 1 bit (800 ns).
- `TBIT_CYC`, 63: total bit period; must exceed `T1H_CYC`.
- `LATCH_CYC`, 2500: low latch/reset time after the last bit (50 µs).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: frame request; sampled only in IDLE.
- `px_valid` input 1: source holds a valid pixel.
- `px_data` input 24: pixel word; bit 23 is transmitted first.
- `px_ready` output 1: block accepts a pixel this cycle.
- `led_out` output 1: serial LED data line.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse at frame completion.
- `underrun` output 1: sticky flag, set when no pixel is available when one is needed.

## Operation
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE: `led_out`=0. If `start`=1, clear `underrun`, clear the pixel counter, and go to LOAD.
- LOAD: exactly 1 cycle. `px_ready`=1 and `led_out`=0.
  - `px_valid`=1: latch `px_data` into the shift register, set bit index to 23, and go to HIGH.
  - `px_valid`=0: set `underrun` and handle it per Configuration.
- HIGH: `led_out`=1 for `T1H_CYC` cycles if the current bit is 1, else `T0H_CYC` cycles. Then go to LOW.
- LOW: `led_out`=0 for `TBIT_CYC` − high time. Then:
  - more bits remain: shift, go to HIGH;
  - last bit of the pixel and pixel count < `NUM_LEDS`: go to LOAD;
  - last bit of the last pixel: go to LATCH.
- LATCH: `led_out`=0 for `LATCH_CYC` cycles, then go to IDLE. `done`=1 in the first IDLE cycle.
- `start` is ignored whenever `busy`=1. It is not queued.
- Counter widths: $clog2 of the largest value each counter holds. No wrap occurs inside a legal frame.
- `px_ready` is high only in LOAD. A transfer happens only when `px_valid` and `px_ready` are both high.

## Timing
- Reset values: `led_out`=0, `px_ready`=0, `busy`=0, `done`=0, `underrun`=0, state=IDLE.
- Reset is asynchronous: when asserted mid-frame, `led_out` drops low immediately and the frame is discarded.
- Every bit period is exactly `TBIT_CYC` cycles. Each pixel adds 1 LOAD cycle, so one pixel takes 1 + 24·`TBIT_CYC` cycles.
- Frame busy length: `NUM_LEDS`·(1 + 24·`TBIT_CYC`) + `LATCH_CYC` cycles.
- `start`→`busy`: 1 cycle. `start`→first `px_ready`: 1 cycle. First `led_out` rise: 1 cycle after the accepted LOAD.
- If `start` is high in the same cycle `done` pulses, it is accepted, because the state is IDLE.

## Configuration
- `LED_REPEAT_ON_UNDERRUN_EN`:
  - Defined: on underrun, `underrun` is set and the previously latched pixel is retransmitted. The frame completes with full length. If the very first pixel underruns, 24'h000000 is transmitted.
  - Not defined: on underrun, `underrun` is set, the frame aborts directly to LATCH (full `LATCH_CYC`), and `done` still pulses.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs 0. Release → still IDLE until `start`.
- `NUM_LEDS`=1, default timing, `px_data`=24'hF00000, `px_valid` held → exact 1-cycle `px_ready`; `led_out` high for 4×40 then 20×20 cycles, each bit period 63; `done` 1513+2500 cycles after LOAD entry.
- `NUM_LEDS`=2, `px_valid` held → two `px_ready` pulses 1513 cycles apart; `busy` high for 5526 cycles; `underrun`=0.
- `NUM_LEDS`=2, `px_valid`=0 at the second LOAD:
  - macro off → `underrun`=1, LATCH entered, `done` 1 cycle after 2500 low cycles;
  - macro on → second pixel equals the first, full 5526-cycle frame.
- `start` pulsed during HIGH, LOW and LATCH → ignored; exactly one `done` per accepted start.
- `rst_n` pulled low during a HIGH phase → `led_out`=0 in the same cycle. After release, IDLE; the next `start` gives a full, correct frame.
